// File: rtl/cache_port_arbiter_pkg.sv
// Shared definitions for the cache port arbiter and the cache controller
// requesters that drive it.
package cache_port_arbiter_pkg;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or above
// ptr (wrapping), returning a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int LG_N = 2
) (
  input  logic [N-1:0]    req,
  input  logic [LG_N-1:0] ptr,
  input  logic            enable,
  output logic [N-1:0]    grant,
  output logic [LG_N-1:0] grant_idx
);

  // N is a power of two, so the LG_N-bit sum wraps modulo N for free.
  always_comb begin
    logic [LG_N-1:0] idx;
    logic            found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + LG_N'(k);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache SRAM port among NUM_REQ requesters with round-robin
// fairness; at most one read response is outstanding at a time.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LG_NUM_REQ = 2,
  parameter int WIDTH      = 128,
  parameter int LG_DEPTH   = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*LG_DEPTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]    req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [LG_NUM_REQ-1:0]       resp_id,
  output logic [WIDTH-1:0]            resp_rdata,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [LG_DEPTH-1:0]         ram_addr,
  output logic [WIDTH-1:0]            ram_din,
  input  logic [WIDTH-1:0]            ram_dout
);

  logic [LG_NUM_REQ-1:0] rr_ptr_q, rr_ptr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [LG_NUM_REQ-1:0] resp_id_q, resp_id_d;

  logic                  can_issue;
  logic [NUM_REQ-1:0]    grant;
  logic [LG_NUM_REQ-1:0] grant_idx;
  logic                  grant_valid;
  logic                  grant_is_write;

  // Any SRAM access while a response is held would overwrite ram_dout, so
  // granting stops until the consumer takes it; nothing is granted in reset.
  assign can_issue = rst_n && (!resp_valid_q || resp_ready);

  rr_arbiter #(
    .N    (NUM_REQ),
    .LG_N (LG_NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .enable    (can_issue),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_valid    = |grant;
  assign grant_is_write = req_type_e'(req_write[grant_idx]) == REQ_WRITE;

  always_comb begin
    req_ready = grant;
    ram_en    = grant_valid;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    if (grant_valid) begin
      ram_we   = grant_is_write;
      ram_addr = req_addr[grant_idx*LG_DEPTH +: LG_DEPTH];
      ram_din  = req_wdata[grant_idx*WIDTH +: WIDTH];
    end
  end

  // A read granted in the same cycle a response is consumed keeps
  // resp_valid high and simply retags it with the new requester.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    if (grant_valid) begin
      rr_ptr_d = grant_idx + LG_NUM_REQ'(1);
    end
    if (grant_valid && !grant_is_write) begin
      resp_valid_d = 1'b1;
      resp_id_d    = grant_idx;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_rdata = ram_dout;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a behavioural SRAM on the port
// and a scoreboard of expected read responses.
module tb_cache_port_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int LG_NUM_REQ = 2;
  localparam int WIDTH      = 128;
  localparam int LG_DEPTH   = 6;

  typedef struct packed {
    logic [LG_NUM_REQ-1:0] id;
    logic [WIDTH-1:0]      data;
  } sb_entry_t;

  logic                        clk;
  logic                        rst_n;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*LG_DEPTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]    req_wdata;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [LG_NUM_REQ-1:0]       resp_id;
  logic [WIDTH-1:0]            resp_rdata;
  logic                        ram_en;
  logic                        ram_we;
  logic [LG_DEPTH-1:0]         ram_addr;
  logic [WIDTH-1:0]            ram_din;
  logic [WIDTH-1:0]            ram_dout;

  logic [LG_DEPTH-1:0] addr_tb  [NUM_REQ];
  logic [WIDTH-1:0]    wdata_tb [NUM_REQ];
  logic [WIDTH-1:0]    mem      [1<<LG_DEPTH];
  logic [WIDTH-1:0]    ref_mem  [1<<LG_DEPTH];
  sb_entry_t           sb [$];

  int n_compared;
  int n_mismatched;

  cache_port_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .LG_NUM_REQ (LG_NUM_REQ),
    .WIDTH      (WIDTH),
    .LG_DEPTH   (LG_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_rdata (resp_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*LG_DEPTH +: LG_DEPTH] = addr_tb[i];
      req_wdata[i*WIDTH +: WIDTH]      = wdata_tb[i];
    end
  end

  // Registered-output SRAM; dout also updates on writes (write-first).
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        ram_dout      <= ram_din;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  function automatic logic [WIDTH-1:0] preload(input int a);
    logic [25:0] tag;
    tag = 26'h2A5A5A5;
    return {4{tag, 6'(a)}};
  endfunction

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of requests, checks the held response and the grant,
  // records the expected read result, then advances past the clock edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                               input logic [NUM_REQ-1:0] write,
                               input logic rready,
                               input logic [NUM_REQ-1:0] exp_grant);
    sb_entry_t e;
    int g;
    req_valid  = valid;
    req_write  = write;
    resp_ready = rready;
    #1;
    checkOutput("resp_valid", resp_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      checkOutput("resp_id", resp_id, sb[0].id);
      checkOutput("resp_rdata", resp_rdata, sb[0].data);
      if (rready) void'(sb.pop_front());
    end
    checkOutput("req_ready", req_ready, exp_grant);
    checkOutput("ram_en", ram_en, |exp_grant);
    if (exp_grant != '0) begin
      g = 0;
      for (int i = 0; i < NUM_REQ; i++) if (exp_grant[i]) g = i;
      checkOutput("ram_we", ram_we, write[g]);
      checkOutput("ram_addr", ram_addr, addr_tb[g]);
      if (write[g]) begin
        checkOutput("ram_din", ram_din, wdata_tb[g]);
        ref_mem[addr_tb[g]] = wdata_tb[g];
      end else begin
        e.id   = LG_NUM_REQ'(g);
        e.data = ref_mem[addr_tb[g]];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int a = 0; a < (1 << LG_DEPTH); a++) begin
      mem[a]     = preload(a);
      ref_mem[a] = preload(a);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_tb[i]  = LG_DEPTH'(i * 7 + 3);
      wdata_tb[i] = '0;
    end
    ram_dout   = '0;
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_write  = 4'b0000;
    resp_ready = 1'b1;

    // Reset: all requesters valid, nothing granted.
    #12;
    checkOutput("reset req_ready", req_ready, 4'b0000);
    checkOutput("reset resp_valid", resp_valid, 1'b0);
    checkOutput("reset ram_en", ram_en, 1'b0);
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;

    // Round robin with every requester reading continuously.
    applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0001);
    applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0010);
    applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0100);
    applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b1000);
    applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0001);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Back-pressure on a read by requester 2 at address 5.
    addr_tb[2] = 6'd5;
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0100);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0100);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Write then read of the same address by different requesters.
    addr_tb[1]  = 6'd9;
    wdata_tb[1] = {8{16'hDEAD}};
    applyStimulus(4'b0010, 4'b0010, 1'b1, 4'b0010);
    addr_tb[3] = 6'd9;
    applyStimulus(4'b1000, 4'b0000, 1'b1, 4'b1000);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Sparse fairness: move the pointer to 2, then only 1 and 3 compete.
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b0010);
    applyStimulus(4'b1010, 4'b0000, 1'b1, 4'b1000);
    applyStimulus(4'b1010, 4'b0000, 1'b1, 4'b0010);
    applyStimulus(4'b1010, 4'b0000, 1'b1, 4'b1000);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Reset while a read response is pending.
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0100);
    req_valid = 4'b0000;
    checkOutput("pre-reset resp_valid", resp_valid, 1'b1);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    checkOutput("mid-reset resp_valid", resp_valid, 1'b0);
    checkOutput("mid-reset resp_id", resp_id, 2'd0);
    checkOutput("mid-reset req_ready", req_ready, 4'b0000);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0001);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
